// File: rtl/insn_exec_ctrl_if.sv
// IP-line fetch interface: execution side is master (drives Request), IP line is slave.
interface insn_exec_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  Request;
  logic                  Ready;
  logic [3:0]            Insn;
  logic [ADDR_WIDTH-1:0] Address;

  modport master (output Request, input Ready, input Insn, input Address);
  modport slave  (input Request, output Ready, output Insn, output Address);
endinterface

// File: rtl/insn_exec_ctrl.sv
// Execution-side initiator: fetches instructions over the IP line and executes
// increment/decrement/halt against a local data register.
module insn_exec_ctrl #(
  parameter int unsigned DATA_WIDTH    = 11,
  parameter int unsigned RETIRED_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 4096,
  parameter int unsigned ADDR_WIDTH    = 24
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Start,
  input  logic                     Stop,
  insn_exec_ctrl_if.master         ip,
  output logic                     dataIsZeroed,
  output logic [DATA_WIDTH-1:0]    Data,
  output logic [RETIRED_WIDTH-1:0] InsnRetired,
  output logic [ADDR_WIDTH-1:0]    LastAddr,
  output logic                     Busy,
  output logic                     Halted,
  output logic                     Error
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] INSN_HALT = 4'b0001;
  localparam logic [3:0] INSN_INC  = 4'b0010;
  localparam logic [3:0] INSN_DEC  = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic                     readyq_q;
  logic [3:0]               insn_q, insn_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [RETIRED_WIDTH-1:0] retired_q, retired_d;
  logic [ADDR_WIDTH-1:0]    last_addr_q, last_addr_d;
  logic                     request_q, busy_q, halted_q, error_q, zero_q;
  logic                     ready_rise_c;

  // Only a low-to-high transition of Ready counts as a completed fetch.
  assign ready_rise_c = ip.Ready & ~readyq_q;

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      readyq_q    <= 1'b0;
      insn_q      <= 4'b0000;
      cnt_q       <= '0;
      data_q      <= '0;
      retired_q   <= '0;
      last_addr_q <= '0;
      request_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      readyq_q    <= ip.Ready;
      insn_q      <= insn_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      retired_q   <= retired_d;
      last_addr_q <= last_addr_d;
      request_q   <= (state_d == ST_REQ);
      busy_q      <= (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_EXEC);
      halted_q    <= (state_d == ST_HALTED);
      error_q     <= (state_d == ST_ERROR);
      zero_q      <= (data_d == '0);
    end
  end

  // Next-state, fetch capture, timeout counting and instruction execution.
  always_comb begin
    state_d     = state_q;
    insn_d      = insn_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    retired_d   = retired_q;
    last_addr_d = last_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_REQ;
      end
      ST_REQ: begin
        cnt_d = '0;
        if (ready_rise_c) begin
          insn_d      = ip.Insn;
          last_addr_d = ip.Address;
          state_d     = ST_EXEC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ready_rise_c) begin
          insn_d      = ip.Insn;
          last_addr_d = ip.Address;
          cnt_d       = '0;
          state_d     = ST_EXEC;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + RETIRED_WIDTH'(1);
        if (insn_q == INSN_INC)      data_d = data_q + DATA_WIDTH'(1);
        else if (insn_q == INSN_DEC) data_d = data_q - DATA_WIDTH'(1);
        // Halt takes priority over a pending Stop.
        if (insn_q == INSN_HALT) state_d = ST_HALTED;
        else if (Stop)           state_d = ST_IDLE;
        else                     state_d = ST_REQ;
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign ip.Request   = request_q;
  assign Busy         = busy_q;
  assign Halted       = halted_q;
  assign Error        = error_q;
  assign Data         = data_q;
  assign dataIsZeroed = zero_q;
  assign InsnRetired  = retired_q;
  assign LastAddr     = last_addr_q;

endmodule

// File: tb/tb_insn_exec_ctrl.sv
// Self-checking bench for insn_exec_ctrl: IP-line responder, behavioural model,
// per-cycle comparison plus directed literal checks.
module tb_insn_exec_ctrl;

  localparam int unsigned DW   = 11;
  localparam int unsigned RW   = 32;
  localparam int unsigned TO   = 16;
  localparam int unsigned AW   = 24;
  localparam longint      DMOD = 2048;
  localparam longint      RMOD = 64'h1_0000_0000;

  localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_EXEC = 3, M_HALT = 4, M_ERR = 5;

  logic          Clk, Rst_n, Start, Stop;
  logic          dataIsZeroed, Busy, Halted, Error;
  logic [DW-1:0] Data;
  logic [RW-1:0] InsnRetired;
  logic [AW-1:0] LastAddr;

  insn_exec_ctrl_if #(.ADDR_WIDTH(AW)) ipif ();

  insn_exec_ctrl #(
    .DATA_WIDTH(DW), .RETIRED_WIDTH(RW), .TIMEOUT(TO), .ADDR_WIDTH(AW)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stop(Stop), .ip(ipif),
    .dataIsZeroed(dataIsZeroed), .Data(Data), .InsnRetired(InsnRetired),
    .LastAddr(LastAddr), .Busy(Busy), .Halted(Halted), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- IP-line responder ----------------
  bit         resp_en   = 1'b1;
  bit         resp_rand = 1'b0;
  int         resp_delay = 5;
  int         resp_hold  = 1;
  logic [3:0] iq[$];
  int         served = 0;

  initial begin
    int d, h;
    logic [3:0] ins;
    int r;
    ipif.Ready   = 1'b0;
    ipif.Insn    = 4'b0000;
    ipif.Address = '0;
    forever begin
      @(negedge Clk); #1;
      if (!Rst_n) served = req_cnt;
      else if (resp_en && req_cnt > served) begin
        served++;
        d = resp_rand ? int'($urandom_range(0, 6)) : resp_delay;
        h = resp_rand ? int'($urandom_range(1, 3)) : resp_hold;
        if (iq.size() > 0) ins = iq.pop_front();
        else begin
          r = int'($urandom_range(0, 9));
          if (r == 0)      ins = 4'b0001;
          else if (r < 4)  ins = 4'b0010;
          else if (r < 7)  ins = 4'b0011;
          else             ins = 4'($urandom);
        end
        if (d > 0) begin repeat (d) @(posedge Clk); #2; end
        ipif.Insn    = ins;
        ipif.Address = AW'($urandom);
        ipif.Ready   = 1'b1;
        repeat (h) @(posedge Clk);
        #2 ipif.Ready = 1'b0;
        // keep Ready low for a full cycle so the next edge is visible
        @(posedge Clk);
      end
    end
  end

  // ---------------- behavioural model ----------------
  bit         m_valid = 1'b0;
  int         m_st;
  bit         m_rq;
  longint     m_data, m_ret, m_last;
  int         m_insn, m_wait;

  always @(posedge Clk) begin
    bit rise;
    rise = ipif.Ready && !m_rq;
    m_rq = ipif.Ready;
    if (!Rst_n) begin
      m_valid = 1'b1;
      m_st = M_IDLE; m_rq = 1'b0; m_data = 0; m_ret = 0; m_last = 0;
      m_insn = 0; m_wait = 0;
    end else if (m_valid) begin
      case (m_st)
        M_IDLE: if (Start) m_st = M_REQ;
        M_REQ, M_WAIT: begin
          if (m_st == M_REQ) m_wait = 0;
          if (rise) begin
            m_insn = int'(ipif.Insn);
            m_last = longint'(ipif.Address);
            m_st   = M_EXEC;
          end else if (m_st == M_REQ) begin
            m_st = M_WAIT;
          end else begin
            m_wait++;
            if (m_wait == int'(TO)) m_st = M_ERR;
          end
        end
        M_EXEC: begin
          m_ret = (m_ret + 1) % RMOD;
          if (m_insn == 2) m_data = (m_data + 1) % DMOD;
          if (m_insn == 3) m_data = (m_data + DMOD - 1) % DMOD;
          if (m_insn == 1)  m_st = M_HALT;
          else if (Stop)    m_st = M_IDLE;
          else              m_st = M_REQ;
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("Request",      longint'(ipif.Request), longint'(m_st == M_REQ));
      chk("Busy",         longint'(Busy), longint'(m_st == M_REQ || m_st == M_WAIT || m_st == M_EXEC));
      chk("Halted",       longint'(Halted), longint'(m_st == M_HALT));
      chk("Error",        longint'(Error), longint'(m_st == M_ERR));
      chk("Data",         longint'(Data), m_data);
      chk("dataIsZeroed", longint'(dataIsZeroed), longint'(m_data == 0));
      chk("InsnRetired",  longint'(InsnRetired), m_ret);
      chk("LastAddr",     longint'(LastAddr), m_last);
    end
    if (ipif.Request === 1'b1) req_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk); #2;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Start = 1'b0;
    iq.delete();
    tick(); tick();
    Rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (!(Halted || Error) && n < 300) begin tick(); n++; end
    chk(nm, longint'(Halted), 1);
  endtask

  initial begin
    int r0, n;
    Rst_n = 1'b0; Start = 1'b0; Stop = 1'b0;
    tick(); tick();
    Rst_n = 1'b1;

    // reset values
    chk("rst_Data", longint'(Data), 0);
    chk("rst_zero", longint'(dataIsZeroed), 1);
    chk("rst_retired", longint'(InsnRetired), 0);
    chk("rst_lastaddr", longint'(LastAddr), 0);
    chk("rst_flags", longint'({ipif.Request, Busy, Halted, Error}), 0);

    // three increments then halt, Ready 5 cycles after each Request
    resp_en = 1; resp_rand = 0; resp_delay = 5; resp_hold = 1;
    iq = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
    r0 = req_cnt;
    pulse_start();
    wait_halt("s1_halted");
    repeat (6) tick();
    chk("s1_Data", longint'(Data), 3);
    chk("s1_zero", longint'(dataIsZeroed), 0);
    chk("s1_retired", longint'(InsnRetired), 4);
    chk("s1_requests", req_cnt - r0, 4);

    // decrement wraps 0 -> 2047
    do_reset();
    iq = '{4'b0011, 4'b0001};
    pulse_start();
    wait_halt("s2_halted");
    chk("s2_Data", longint'(Data), 2047);
    chk("s2_retired", longint'(InsnRetired), 2);

    // increment wraps 2047 -> 0
    do_reset();
    resp_delay = 0;
    iq = '{4'b0011, 4'b0010, 4'b0001};
    pulse_start();
    wait_halt("s2b_halted");
    chk("s2b_Data", longint'(Data), 0);
    chk("s2b_zero", longint'(dataIsZeroed), 1);
    chk("s2b_retired", longint'(InsnRetired), 3);

    // NOP codes
    do_reset();
    resp_delay = 2;
    iq = '{4'b0000, 4'b0100, 4'b1111, 4'b0001};
    r0 = req_cnt;
    pulse_start();
    wait_halt("s3_halted");
    chk("s3_Data", longint'(Data), 0);
    chk("s3_retired", longint'(InsnRetired), 4);
    chk("s3_requests", req_cnt - r0, 4);

    // Ready held high for 10 cycles counts once
    do_reset();
    resp_delay = 0; resp_hold = 10;
    iq = '{4'b0010, 4'b0001};
    r0 = req_cnt;
    pulse_start();
    n = 0;
    while (req_cnt - r0 < 2 && n < 50) begin tick(); n++; end
    repeat (5) tick();
    chk("s4_mid_retired", longint'(InsnRetired), 1);
    chk("s4_mid_busy", longint'(Busy), 1);
    wait_halt("s4_halted");
    chk("s4_retired", longint'(InsnRetired), 2);
    chk("s4_Data", longint'(Data), 1);
    chk("s4_requests", req_cnt - r0, 2);
    resp_hold = 1;

    // fetch timeout
    do_reset();
    resp_en = 0;
    pulse_start();
    n = 0;
    while (!Error && n < 40) begin tick(); n++; end
    chk("s5_latency", n, 17);
    chk("s5_busy", longint'(Busy), 0);
    r0 = req_cnt;
    pulse_start();
    repeat (3) tick();
    chk("s5_error_sticky", longint'(Error), 1);
    chk("s5_no_request", req_cnt - r0, 0);
    do_reset();
    chk("s5_error_cleared", longint'(Error), 0);
    resp_en = 1;

    // Stop during WAIT, then resume with Stop still high and halt
    resp_delay = 5;
    iq = '{4'b0010};
    r0 = req_cnt;
    pulse_start();
    tick(); tick();
    Stop = 1'b1;
    n = 0;
    while (InsnRetired != 1 && n < 40) begin tick(); n++; end
    repeat (2) tick();
    chk("s6_Data", longint'(Data), 1);
    chk("s6_busy", longint'(Busy), 0);
    chk("s6_halted", longint'(Halted), 0);
    repeat (10) tick();
    chk("s6_requests", req_cnt - r0, 1);
    iq = '{4'b0001};
    pulse_start();
    wait_halt("s6_halt_with_stop");
    chk("s6_requests2", req_cnt - r0, 2);
    Stop = 1'b0;

    // randomized traffic
    do_reset();
    resp_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      if (Halted || Error || $urandom_range(0, 199) == 0) do_reset();
      Start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) Stop = ~Stop;
      tick();
    end
    Start = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
